// File: rtl/serial_record_pkg.sv
// Shared constants and state types for the serial vehicle-record receiver.
package serial_record_pkg;

  localparam logic [7:0] HEADER        = 8'hA5;
  localparam int unsigned REC_BYTES     = 4;
  localparam int unsigned EPASS_BIT     = 7;
  localparam int unsigned BARRIER_BIT   = 6;
  localparam int unsigned SPEED_HI_BITS = 6;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } byte_state_e;

  typedef enum logic [1:0] {
    StHunt,
    StGot0,
    StGot1,
    StGot2
  } rec_state_e;

  // Checksum byte of a record: XOR of the three preceding bytes.
  function automatic logic [7:0] rec_checksum(input logic [7:0] b1, input logic [7:0] b2);
    return HEADER ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: input synchronizer, baud counter and byte FSM.
module uart_rx_byte
  import serial_record_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1041
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]       r_sync;
  logic             r_rx_prev;
  logic             w_rx;
  logic             w_fall;
  byte_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;

  // Reset to idle-high so a reset never fabricates a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], serial_in};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (w_fall) r_state <= StStart;
        end
        StStart: begin
          if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
            r_cnt   <= '0;
            r_state <= w_rx ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= StStop;
            r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            r_cnt      <= '0;
            byte_data  <= r_shift;
            byte_valid <= w_rx;
            byte_ferr  <= ~w_rx;
            r_state    <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/serial_record_rx.sv
// Assembles 4-byte vehicle records from the UART byte stream and validates them.
module serial_record_rx
  import serial_record_pkg::*;
#(
  parameter int unsigned SYS_FREQ     = 10_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned WIDTH_SPEED  = 14,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   serial_in,
  output logic                   rec_valid,
  output logic [WIDTH_SPEED-1:0] rec_speed,
  output logic                   rec_epass,
  output logic                   rec_barrier,
  output logic                   frame_err,
  output logic                   chk_err
);

  localparam int unsigned CLKS_PER_BIT = SYS_FREQ / BAUD_RATE;
  localparam int unsigned TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W        = $clog2(TMO_LIMIT + 1);

  logic [7:0]       w_byte_data;
  logic             w_byte_valid;
  logic             w_byte_ferr;
  rec_state_e       r_state;
  logic [7:0]       r_xor;
  logic [7:0]       r_b1;
  logic [7:0]       r_b2;
  logic [TMO_W-1:0] r_tmo;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .byte_ferr (w_byte_ferr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StHunt;
      r_xor       <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_tmo       <= '0;
      rec_valid   <= 1'b0;
      rec_speed   <= '0;
      rec_epass   <= 1'b0;
      rec_barrier <= 1'b0;
      frame_err   <= 1'b0;
      chk_err     <= 1'b0;
    end else begin
      rec_valid <= 1'b0;
      frame_err <= 1'b0;
      chk_err   <= 1'b0;
      if (w_byte_ferr) begin
        frame_err <= 1'b1;
        r_state   <= StHunt;
        r_tmo     <= '0;
      end else if (w_byte_valid) begin
        r_tmo <= '0;
        case (r_state)
          StHunt: begin
            if (w_byte_data == HEADER) begin
              r_xor   <= HEADER;
              r_state <= StGot0;
            end
          end
          StGot0: begin
            r_b1    <= w_byte_data;
            r_xor   <= r_xor ^ w_byte_data;
            r_state <= StGot1;
          end
          StGot1: begin
            r_b2    <= w_byte_data;
            r_xor   <= r_xor ^ w_byte_data;
            r_state <= StGot2;
          end
          StGot2: begin
            if (w_byte_data == r_xor) begin
              rec_valid   <= 1'b1;
              rec_speed   <= WIDTH_SPEED'({r_b1[SPEED_HI_BITS-1:0], r_b2});
              rec_epass   <= r_b1[EPASS_BIT];
              rec_barrier <= r_b1[BARRIER_BIT];
            end else begin
              chk_err <= 1'b1;
            end
            r_state <= StHunt;
          end
          default: r_state <= StHunt;
        endcase
      end else if (r_state != StHunt) begin
        // Idle gap inside a record; byte_valid above takes priority.
        if (r_tmo == TMO_W'(TMO_LIMIT - 1)) begin
          frame_err <= 1'b1;
          r_state   <= StHunt;
          r_tmo     <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_record_rx.sv
// Scoreboard bench: expected record events are queued as frames are sent, checked on strobes.
module tb_serial_record_rx;

  localparam int unsigned SysFreq  = 1_000_000;
  localparam int unsigned Baud     = 62_500;
  localparam int unsigned Cpb      = SysFreq / Baud;
  localparam int unsigned TmoBits  = 20;
  localparam int EvRec   = 0;
  localparam int EvChk   = 1;
  localparam int EvFrame = 2;
  localparam int EvNone  = 3;

  typedef struct {
    int          kind;
    logic [13:0] speed;
    logic        epass;
    logic        barrier;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        serial_in;
  logic        rec_valid;
  logic [13:0] rec_speed;
  logic        rec_epass;
  logic        rec_barrier;
  logic        frame_err;
  logic        chk_err;

  exp_t        sb[$];
  logic [13:0] m_speed;
  logic        m_epass;
  logic        m_barrier;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  logic        prev_any = 1'b0;
  logic        w_any;
  int          w_kind;

  serial_record_rx #(
    .SYS_FREQ    (SysFreq),
    .BAUD_RATE   (Baud),
    .WIDTH_SPEED (14),
    .TIMEOUT_BITS(TmoBits)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .rec_valid  (rec_valid),
    .rec_speed  (rec_speed),
    .rec_epass  (rec_epass),
    .rec_barrier(rec_barrier),
    .frame_err  (frame_err),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign w_any  = rec_valid | chk_err | frame_err;
  assign w_kind = rec_valid ? EvRec : (chk_err ? EvChk : EvFrame);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (reset_n && w_any) begin
      check_eq("strobe_onehot", $countones({rec_valid, chk_err, frame_err}), 1);
      check_eq("strobe_len", prev_any, 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", w_kind, EvNone);
      end else begin
        e = sb.pop_front();
        check_eq("ev_kind", w_kind, e.kind);
        check_eq("rec_speed", rec_speed, e.speed);
        check_eq("rec_epass", rec_epass, e.epass);
        check_eq("rec_barrier", rec_barrier, e.barrier);
        check_eq("ev_window", (cyc >= e.lo) && (cyc <= e.hi), 1);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_step();
    prev_any <= w_any;
  end

  task automatic push_ev(input int kind, input int unsigned lo, input int unsigned hi);
    exp_t e;
    e.kind    = kind;
    e.speed   = m_speed;
    e.epass   = m_epass;
    e.barrier = m_barrier;
    e.lo      = lo;
    e.hi      = hi;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * Cpb) @(negedge clk);
  endtask

  // Sends A5,b1,b2,b3 back to back; the bench decides good/bad from its own XOR.
  task automatic send_rec(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(8'hA5, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    if (b3 == (8'hA5 ^ b1 ^ b2)) begin
      m_speed   = {b1[5:0], b2};
      m_epass   = b1[7];
      m_barrier = b1[6];
      push_ev(EvRec, cyc + 9 * Cpb, cyc + 10 * Cpb + 4);
    end else begin
      push_ev(EvChk, cyc + 9 * Cpb, cyc + 10 * Cpb + 4);
    end
    send_byte(b3, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, rec_valid, 0);
    check_eq({tag, "_speed"}, rec_speed, 0);
    check_eq({tag, "_epass"}, rec_epass, 0);
    check_eq({tag, "_barrier"}, rec_barrier, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
    check_eq({tag, "_chk_err"}, chk_err, 0);
  endtask

  initial begin
    serial_in = 1'b1;
    reset_n   = 1'b0;
    m_speed   = '0;
    m_epass   = 1'b0;
    m_barrier = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("rst");
    reset_n = 1'b1;
    idle_bits(2);

    // Good record: speed 300, both flags set.
    send_rec(8'hC1, 8'h2C, 8'h48);
    idle_bits(2);
    check_eq("spd300", rec_speed, 14'd300);

    // Checksum error keeps the previous fields.
    send_rec(8'h40, 8'h50, 8'h00);
    idle_bits(2);

    // Bad stop bit inside a record, then recovery.
    send_byte(8'hA5, 1'b1);
    push_ev(EvFrame, cyc + 9 * Cpb, cyc + 10 * Cpb + 4);
    send_byte(8'h55, 1'b0);
    idle_bits(3);
    send_rec(8'h02, 8'h10, 8'hB7);
    idle_bits(2);

    // Inter-byte timeout after B1, then recovery.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    push_ev(EvFrame, cyc + 19 * Cpb, cyc + 21 * Cpb);
    idle_bits(25);
    send_rec(8'h80, 8'h05, 8'h20);
    idle_bits(2);

    // Junk bytes while hunting, then max speed record back to back.
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_rec(8'h7F, 8'hFF, 8'h25);
    // Header value used as payload must not resync.
    send_rec(8'hA5, 8'hA5, 8'hA5);
    idle_bits(2);

    // Short low glitch: no byte, no strobe.
    serial_in = 1'b0;
    repeat (Cpb * 3 / 10) @(negedge clk);
    idle_bits(12);

    // Reset in the middle of B2.
    send_byte(8'hA5, 1'b1);
    send_byte(8'hC1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midrst");
    serial_in = 1'b1;
    m_speed   = '0;
    m_epass   = 1'b0;
    m_barrier = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_bits(3);
    send_rec(8'h41, 8'h00, 8'hE4);
    idle_bits(3);

    check_eq("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
